sobel_tile_engine: RTL and testbench
====================================

SOBEL_TILE_ENGINE -- requirements
Module: sobel_tile_engine

Interface
REQ-001 Parameter DATA_W, default 9: unsigned pixel width.
REQ-002 Parameter TILE, default 4: output tile edge; input tile edge is TILE+2.
REQ-003 Parameter OUT_W, default DATA_W+3: signed gradient width, two's complement.
REQ-004 Port clk, input, 1: single clock, rising edge.
REQ-005 Port rst, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: request to process tile_in; honoured only in IDLE.
REQ-007 Port tile_in, input, (TILE+2)*(TILE+2)*DATA_W: row-major pixels; pixel [r][c] at bit offset ((r*(TILE+2))+c)*DATA_W.
REQ-008 Port busy, output, 1: high in CALC and DONE states.
REQ-009 Port done, output, 1: one-cycle pulse when all results are valid.
REQ-010 Port gx_out, output, TILE*TILE*OUT_W: horizontal gradients, row-major, same packing rule as tile_in.
REQ-011 Port gy_out, output, TILE*TILE*OUT_W: vertical gradients, same packing.

Function
REQ-012 FSM SHALL have states IDLE, CALC, DONE.
REQ-013 IDLE with start=1: capture tile_in into an internal buffer, clear the row counter, go to CALC.
REQ-014 IDLE with start=0: remain in IDLE; outputs hold their values.
REQ-015 CALC: each cycle, compute one output row (row counter value r) from the buffered rows r..r+2, write it into gx_out/gy_out, and increment the counter.
REQ-016 CALC SHALL go to DONE after the row TILE-1 write, i.e. after exactly TILE cycles.
REQ-017 DONE: assert done for one cycle, then return to IDLE.
REQ-018 Latency: a start sampled at edge 0 produces done=1 during the cycle after edge TILE+1.
REQ-019 gx[r][c] = (p[r][c+2] + 2p[r+1][c+2] + p[r+2][c+2]) - (p[r][c] + 2p[r+1][c] + p[r+2][c]).
REQ-020 gy[r][c] = (p[r+2][c] + 2p[r+2][c+1] + p[r+2][c+2]) - (p[r][c] + 2p[r][c+1] + p[r][c+2]).
REQ-021 Arithmetic: zero-extend pixels, compute in OUT_W signed. No saturation is needed at the default width (magnitude ≤ 4*(2^DATA_W-1)).
REQ-022 start while busy=1 SHALL be ignored; changes on tile_in during CALC SHALL NOT affect results.
REQ-023 start asserted in the DONE cycle SHALL be ignored; start in the following IDLE cycle SHALL be accepted.
REQ-024 Rows not yet written in the current pass SHALL hold their previous-pass values until overwritten.

Reset
REQ-025 rst=1 SHALL force IDLE, busy=0, done=0, gx_out=0, gy_out=0, row counter=0, buffer=0, regardless of state.
REQ-026 Reset asserted mid-CALC SHALL abort the pass; no done pulse follows deassertion.

Configuration
REQ-027 Macro SOBEL_TILE_MAG_EN defined: add port mag_out, output, TILE*TILE*OUT_W, unsigned.
REQ-028 With the macro, each element SHALL be |gx|+|gy|, written in the same cycle as the gx/gy row, reset to 0, and saturated to 2^OUT_W-1.
REQ-029 Macro undefined: no mag_out port and no magnitude logic.

Verification (TILE=4, DATA_W=9)
REQ-030 Flat tile (all pixels 100), start pulse -> done exactly 6 cycles after the start edge; all gx=gy=0.
REQ-031 Ramp p[r][c]=10*c -> all gx=80, all gy=0; busy high for 5 cycles.
REQ-032 Step (rows 0-2 = 0, rows 3-5 = 511) -> gy rows 0 and 3 = 0, gy rows 1 and 2 = 2044; all gx=0.
REQ-033 Second start pulsed 2 cycles into CALC with a different tile -> ignored; results match the first tile; a later start after done is accepted.
REQ-034 rst pulsed at CALC cycle 2 -> all outputs 0 immediately; busy=0; no done pulse.
REQ-035 With SOBEL_TILE_MAG_EN, ramp p[r][c]=500-10*c -> gx=-80, gy=0, mag=80 everywhere.

Source files
------------

// File: rtl/sobel_tile_engine.sv
// sobel_tile_engine: 3x3 Sobel gradients over a (TILE+2)^2 pixel tile.
// The input tile is captured on start; one output row per cycle is then
// written into the registered gx/gy result tiles. done pulses one cycle
// after the DONE state, i.e. in the first IDLE cycle of the next wait.
// Optional magnitude output |gx|+|gy| is enabled by macro SOBEL_TILE_MAG_EN.
module sobel_tile_engine #(
    parameter int DATA_W = 9,
    parameter int TILE   = 4,
    parameter int OUT_W  = DATA_W + 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [(TILE+2)*(TILE+2)*DATA_W-1:0]   tile_in,
    output logic                                  busy,
    output logic                                  done,
    output logic [TILE*TILE*OUT_W-1:0]            gx_out,
    output logic [TILE*TILE*OUT_W-1:0]            gy_out
`ifdef SOBEL_TILE_MAG_EN
    ,
    output logic [TILE*TILE*OUT_W-1:0]            mag_out
`endif
);

    localparam int IN_E  = TILE + 2;
    localparam int CNT_W = $clog2(TILE + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nx;
    logic                    capture;
    logic                    calc_en;

    logic [DATA_W-1:0]       pix_q  [IN_E][IN_E];
    logic [CNT_W-1:0]        row_q;
    int unsigned             row_i;
    logic signed [OUT_W-1:0] gx_q   [TILE][TILE];
    logic signed [OUT_W-1:0] gy_q   [TILE][TILE];
    logic signed [OUT_W-1:0] gx_row [TILE];
    logic signed [OUT_W-1:0] gy_row [TILE];

`ifdef SOBEL_TILE_MAG_EN
    logic [OUT_W-1:0]        mag_q   [TILE][TILE];
    logic [OUT_W-1:0]        mag_row [TILE];
    logic [OUT_W-1:0]        abs_x   [TILE];
    logic [OUT_W-1:0]        abs_y   [TILE];
    logic [OUT_W:0]          mag_sum [TILE];
`endif

    // Zero-extend an unsigned pixel into the signed gradient width.
    function automatic logic signed [OUT_W-1:0] ext(input logic [DATA_W-1:0] p);
        return $signed({{(OUT_W-DATA_W){1'b0}}, p});
    endfunction

    assign row_i = 32'(row_q);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and control decode; start is only honoured in IDLE.
    always_comb begin
        state_nx = state;
        capture  = 1'b0;
        calc_en  = 1'b0;
        busy     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    capture  = 1'b1;
                    state_nx = CALC;
                end
            end
            CALC: begin
                busy    = 1'b1;
                calc_en = 1'b1;
                if (row_q == CNT_W'(TILE - 1)) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Gradients for the output row selected by the row counter.
    always_comb begin
        for (int unsigned c = 0; c < TILE; c++) begin
            gx_row[c] = (ext(pix_q[row_i][c+2]) + ext(pix_q[row_i+1][c+2])
                         + ext(pix_q[row_i+1][c+2]) + ext(pix_q[row_i+2][c+2]))
                      - (ext(pix_q[row_i][c]) + ext(pix_q[row_i+1][c])
                         + ext(pix_q[row_i+1][c]) + ext(pix_q[row_i+2][c]));
            gy_row[c] = (ext(pix_q[row_i+2][c]) + ext(pix_q[row_i+2][c+1])
                         + ext(pix_q[row_i+2][c+1]) + ext(pix_q[row_i+2][c+2]))
                      - (ext(pix_q[row_i][c]) + ext(pix_q[row_i][c+1])
                         + ext(pix_q[row_i][c+1]) + ext(pix_q[row_i][c+2]));
        end
    end

`ifdef SOBEL_TILE_MAG_EN
    // |gx|+|gy| with saturation; negating the most negative value wraps to
    // its correct unsigned magnitude, so OUT_W bits per term suffice.
    always_comb begin
        for (int unsigned c = 0; c < TILE; c++) begin
            abs_x[c]   = gx_row[c][OUT_W-1] ? OUT_W'(-gx_row[c]) : OUT_W'(gx_row[c]);
            abs_y[c]   = gy_row[c][OUT_W-1] ? OUT_W'(-gy_row[c]) : OUT_W'(gy_row[c]);
            mag_sum[c] = {1'b0, abs_x[c]} + {1'b0, abs_y[c]};
            mag_row[c] = mag_sum[c][OUT_W] ? '1 : mag_sum[c][OUT_W-1:0];
        end
    end
`endif

    // Datapath registers: tile capture, row counter, result rows, done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= '0;
            done  <= 1'b0;
            for (int unsigned r = 0; r < IN_E; r++) begin
                for (int unsigned c = 0; c < IN_E; c++) begin
                    pix_q[r][c] <= '0;
                end
            end
            for (int unsigned r = 0; r < TILE; r++) begin
                for (int unsigned c = 0; c < TILE; c++) begin
                    gx_q[r][c]  <= '0;
                    gy_q[r][c]  <= '0;
`ifdef SOBEL_TILE_MAG_EN
                    mag_q[r][c] <= '0;
`endif
                end
            end
        end else begin
            done <= (state == DONE);
            if (capture) begin
                row_q <= '0;
                for (int unsigned r = 0; r < IN_E; r++) begin
                    for (int unsigned c = 0; c < IN_E; c++) begin
                        pix_q[r][c] <= tile_in[((r*IN_E)+c)*DATA_W +: DATA_W];
                    end
                end
            end else if (calc_en) begin
                row_q <= row_q + 1'b1;
                for (int unsigned c = 0; c < TILE; c++) begin
                    gx_q[row_i][c]  <= gx_row[c];
                    gy_q[row_i][c]  <= gy_row[c];
`ifdef SOBEL_TILE_MAG_EN
                    mag_q[row_i][c] <= mag_row[c];
`endif
                end
            end
        end
    end

    // Flatten result arrays into the row-major output buses.
    for (genvar r = 0; r < TILE; r++) begin : g_row
        for (genvar c = 0; c < TILE; c++) begin : g_col
            assign gx_out[((r*TILE)+c)*OUT_W +: OUT_W]  = gx_q[r][c];
            assign gy_out[((r*TILE)+c)*OUT_W +: OUT_W]  = gy_q[r][c];
`ifdef SOBEL_TILE_MAG_EN
            assign mag_out[((r*TILE)+c)*OUT_W +: OUT_W] = mag_q[r][c];
`endif
        end
    end

endmodule

// File: tb/tb_sobel_tile_engine.sv
// Directed self-checking bench for sobel_tile_engine (TILE=4, DATA_W=9).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sobel_tile_engine;

    localparam int DW = 9;
    localparam int T  = 4;
    localparam int OW = 12;
    localparam int IE = T + 2;
    localparam int TW = IE * IE * DW;
    localparam int GW = T * T * OW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [TW-1:0] tile_in;
    logic          busy;
    logic          done;
    logic [GW-1:0] gx_out;
    logic [GW-1:0] gy_out;
`ifdef SOBEL_TILE_MAG_EN
    logic [GW-1:0] mag_out;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sobel_tile_engine #(
        .DATA_W (DW),
        .TILE   (T),
        .OUT_W  (OW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .tile_in (tile_in),
        .busy    (busy),
        .done    (done),
        .gx_out  (gx_out),
`ifdef SOBEL_TILE_MAG_EN
        .mag_out (mag_out),
`endif
        .gy_out  (gy_out)
    );

    task automatic chk(input string tag, input logic [GW-1:0] obs, input logic [GW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [TW-1:0] mk_ramp(input int base, input int step);
        logic [TW-1:0] t;
        t = '0;
        for (int r = 0; r < IE; r++)
            for (int c = 0; c < IE; c++)
                t[((r*IE)+c)*DW +: DW] = DW'(base + step * c);
        return t;
    endfunction

    function automatic logic [TW-1:0] mk_step();
        logic [TW-1:0] t;
        t = '0;
        for (int r = 0; r < IE; r++)
            for (int c = 0; c < IE; c++)
                t[((r*IE)+c)*DW +: DW] = (r < 3) ? DW'(0) : DW'(511);
        return t;
    endfunction

    // Compare every element of one output row against uniform expectations.
    task automatic check_row(input string tag, input int r, input int ex_gx, input int ex_gy);
        for (int c = 0; c < T; c++) begin
            chk($sformatf("%s_gx_r%0dc%0d", tag, r, c),
                GW'(gx_out[((r*T)+c)*OW +: OW]), GW'(OW'(ex_gx)));
            chk($sformatf("%s_gy_r%0dc%0d", tag, r, c),
                GW'(gy_out[((r*T)+c)*OW +: OW]), GW'(OW'(ex_gy)));
        end
    endtask

    task automatic check_grid(input string tag, input int egx[4], input int egy[4]);
        for (int r = 0; r < T; r++)
            check_row(tag, r, egx[r], egy[r]);
    endtask

    // Present a tile with start for one edge; returns at the falling edge after it.
    task automatic start_pass(input logic [TW-1:0] t);
        @(negedge clk);
        tile_in = t;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
    endtask

    // From the falling edge after the start edge: busy for 5 samples, done on the 6th.
    task automatic watch_pass(input string tag);
        for (int k = 0; k < 7; k++) begin
            chk($sformatf("%s_busy_k%0d", tag, k), GW'(busy), GW'(k <= 4));
            chk($sformatf("%s_done_k%0d", tag, k), GW'(done), GW'(k == 5));
            @(negedge clk);
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        tile_in = '0;
        #2;
        chk("rst_busy", GW'(busy), '0);
        chk("rst_done", GW'(done), '0);
        chk("rst_gx", gx_out, '0);
        chk("rst_gy", gy_out, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Flat tile: zero gradients, done six edges after start.
        start_pass(mk_ramp(100, 0));
        watch_pass("flat");
        check_grid("flat", '{0, 0, 0, 0}, '{0, 0, 0, 0});

        // Horizontal ramp 10*c.
        start_pass(mk_ramp(0, 10));
        watch_pass("ramp");
        check_grid("ramp", '{80, 80, 80, 80}, '{0, 0, 0, 0});

        // Step tile; after the first row write the other rows keep ramp results.
        start_pass(mk_step());
        @(negedge clk);
        check_row("hold_new", 0, 0, 0);
        check_row("hold_old", 1, 80, 0);
        repeat (6) @(negedge clk);
        check_grid("step", '{0, 0, 0, 0}, '{0, 2044, 2044, 0});

        // Start plus new tile two cycles into CALC must be ignored.
        start_pass(mk_ramp(0, 10));
        @(negedge clk);
        @(negedge clk);
        tile_in = mk_step();
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("midcalc_busy", GW'(busy), GW'(1'b1));
        @(negedge clk);
        @(negedge clk);
        chk("midcalc_done", GW'(done), GW'(1'b1));
        repeat (2) @(negedge clk);
        chk("midcalc_idle", GW'(busy), '0);
        check_grid("midcalc", '{80, 80, 80, 80}, '{0, 0, 0, 0});
        start_pass(mk_step());
        watch_pass("after_ignore");
        check_grid("after_ignore", '{0, 0, 0, 0}, '{0, 2044, 2044, 0});

        // Start held during the DONE cycle is ignored.
        start_pass(mk_ramp(0, 10));
        repeat (4) @(negedge clk);
        tile_in = mk_ramp(100, 0);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        chk("donecyc_done", GW'(done), GW'(1'b1));
        chk("donecyc_busy", GW'(busy), '0);
        @(negedge clk);
        chk("donecyc_ignored", GW'(busy), '0);
        chk("donecyc_nodone", GW'(done), '0);
        check_grid("donecyc", '{80, 80, 80, 80}, '{0, 0, 0, 0});

        // Start in the IDLE cycle right after DONE is accepted.
        start_pass(mk_ramp(100, 0));
        repeat (5) @(negedge clk);
        chk("b2b_done", GW'(done), GW'(1'b1));
        tile_in = mk_step();
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        watch_pass("b2b");
        check_grid("b2b", '{0, 0, 0, 0}, '{0, 2044, 2044, 0});

        // Reset in the middle of CALC aborts the pass.
        start_pass(mk_ramp(0, 10));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_gx", gx_out, '0);
        chk("abort_gy", gy_out, '0);
        chk("abort_busy", GW'(busy), '0);
        chk("abort_done", GW'(done), '0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("abort_nodone_k%0d", k), GW'(done), '0);
            chk($sformatf("abort_idle_k%0d", k), GW'(busy), '0);
            @(negedge clk);
        end
        check_grid("abort", '{0, 0, 0, 0}, '{0, 0, 0, 0});
        start_pass(mk_ramp(0, 10));
        watch_pass("recover");
        check_grid("recover", '{80, 80, 80, 80}, '{0, 0, 0, 0});

`ifdef SOBEL_TILE_MAG_EN
        // Descending ramp: negative gx, magnitude 80.
        start_pass(mk_ramp(500, -10));
        watch_pass("mag");
        check_grid("mag", '{-80, -80, -80, -80}, '{0, 0, 0, 0});
        for (int i = 0; i < T * T; i++)
            chk($sformatf("mag_e%0d", i), GW'(mag_out[i*OW +: OW]), GW'(80));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
